seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor to the 4-bit combinational ALU. It has WIDTH-bit operands and keeps the same 4-bit logic/arithmetic op encoding with the invert-A/invert-B operand muxes. It adds an iterative unsigned shift-add multiply. Operands enter and results leave through valid/ready handshakes, so the block can sit between pipeline stages in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (minimum 2).
CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived, not to be overridden).

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  operand/op presented.
in_ready  output  1  block accepts operands this cycle.
op  input  5  op[4]=1 selects multiply; otherwise op[3]=invert a, op[2]=invert b and carry-in=1, op[1:0]: 00 and, 01 or, 10 xor, 11 add.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  result registers hold an unconsumed result.
out_ready  input  1  downstream consumes result.
y  output  WIDTH  result (low half of product for multiply).
prod_hi  output  WIDTH  high half of product; 0 for non-multiply ops.
cout  output  1  adder carry-out (add only, else 0).
neg  output  1  ~cout & op[2] for add, else 0.
zero  output  1  y == 0.
overflow  output  1  signed add overflow; for multiply, prod_hi != 0; else 0.
busy  output  1  multiply in progress.

Behaviour:
- Reset (clk edge with rst=1):
  - Outputs: out_valid=0, y=0, prod_hi=0, all flags 0, busy=0.
  - State: returns to IDLE and the iteration counter clears. An in-flight multiply is aborted and its result is discarded.
- States:
  - IDLE: no op in progress; output slot may be empty or holding a result.
  - MUL: iterating a multiply.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Acceptance occurs on an edge where in_valid && in_ready.
- Non-multiply op accepted at edge k:
  - a_mux = op[3] ? ~a : a; b_mux = op[2] ? ~b : b.
  - Adder carry-in = op[2].
  - Result and flags load on edge k, so out_valid=1 the next cycle (latency 1). Full throughput is sustained while out_ready=1.
- Add flags:
  - cout = carry out of bit WIDTH-1.
  - overflow = (a_mux[MSB]==b_mux[MSB]) && (sum[MSB]!=a_mux[MSB]).
  - neg = ~cout & op[2].
- Multiply accepted at edge k:
  - On edge k: operands are latched (op[3:2] ignored, unsigned), the accumulator clears, state moves to MUL, busy=1, counter=0.
  - Each MUL edge: if multiplier LSB=1, add multiplicand to the upper accumulator half; shift right one bit, keeping the carry; counter increments.
  - On edge k+WIDTH: {prod_hi, y} = a*b is written, flags are set (cout=0, neg=0, zero=(y==0), overflow=(prod_hi!=0)), out_valid=1, state returns to IDLE, busy=0.
  - in_ready=0 throughout MUL.
- Output slot:
  - out_valid clears on an edge with out_ready=1, unless a new result loads on that same edge; the new result then replaces the old and out_valid stays 1.
  - y, prod_hi and flags hold stable while out_valid=1 && out_ready=0.
- Backpressure: a completed multiply is only started when the slot can be freed. Because in_ready requires the slot free or being consumed at acceptance, a multiply completion never overwrites an unconsumed result.
- in_valid while in_ready=0 is ignored; the source must hold a, b and op until acceptance.
- WIDTH wrap-around: add results are modulo 2^WIDTH; the carry appears only on cout.

Optional Feature:
SEQ_ALU_SATURATE_EN
- Defined: for add ops with overflow=1, y saturates to the signed limit: sign bit of a_mux=0 gives 0111…1, sign bit of a_mux=1 gives 1000…0. The overflow flag still reports 1; cout is unchanged; zero is evaluated on the saturated y.
- Undefined: add results wrap modulo 2^WIDTH.

Test Plan (WIDTH=8, out_ready=1 unless stated):
1. Reset then idle: rst high 2 cycles -> out_valid=0, y=0, all flags 0, in_ready=1 one cycle after rst drops.
2. Add: op=00011, a=0x7F, b=0x01 -> next cycle y=0x80, overflow=1, cout=0. Same case with SEQ_ALU_SATURATE_EN defined -> y=0x7F, overflow=1.
3. Subtract: op=00111, a=0x05, b=0x05 -> y=0x00, zero=1, cout=1, neg=0. Then a=0x03, b=0x05 -> y=0xFE, cout=0, neg=1.
4. Multiply: op=10000, a=0xFF, b=0xFF -> busy=1 and in_ready=0 for 8 cycles, then y=0x01, prod_hi=0xFE, overflow=1. Also a=0x0C, b=0x0A -> y=0x78, prod_hi=0x00, overflow=0.
5. Backpressure: out_ready=0, issue xor a=0xF0, b=0xFF -> y=0x0F holds and in_ready=0 until out_ready=1. A back-to-back op accepted on the consuming edge -> out_valid stays 1 with the new value.
6. Reset mid-multiply: assert rst on the 4th MUL cycle -> next cycle busy=0, out_valid=0, in_ready=1; a following and-op (a=0xAA, b=0x0F) -> y=0x0A.

Source files
------------

// File: rtl/seq_alu.sv
//======================================================================
// Module   : seq_alu
// Purpose  : Registered WIDTH-bit ALU (and/or/xor/add with operand
//            inversion) plus iterative unsigned shift-add multiply,
//            with valid/ready handshakes on input and output.
//            Optional macro: SEQ_ALU_SATURATE_EN (signed add saturation).
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] prod_hi,
  output logic             cout,
  output logic             neg,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [WIDTH-1:0]  prod_hi_q, prod_hi_d;
  logic              cout_q, cout_d;
  logic              neg_q, neg_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic [WIDTH-1:0]  a_mux, b_mux;
  logic [WIDTH:0]    sum_ext;
  logic              add_ovf;
  logic [WIDTH:0]    step_ext;
  logic [WIDTH-1:0]  hi_next, lo_next;
  logic [WIDTH-1:0]  res;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign a_mux   = op[3] ? ~a : a;
  assign b_mux   = op[2] ? ~b : b;
  assign sum_ext = {1'b0, a_mux} + {1'b0, b_mux} + {{WIDTH{1'b0}}, op[2]};
  assign add_ovf = (a_mux[WIDTH-1] == b_mux[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a_mux[WIDTH-1]);

  // One shift-add step: carry of the partial sum re-enters the top bit,
  // the partial sum LSB shifts down into the product low half.
  assign step_ext = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign hi_next  = step_ext[WIDTH:1];
  assign lo_next  = {step_ext[0], lo_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    y_d         = y_q;
    prod_hi_d   = prod_hi_q;
    cout_d      = cout_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    res         = {WIDTH{1'b0}};

    unique case (op[1:0])
      2'b00:   res = a_mux & b_mux;
      2'b01:   res = a_mux | b_mux;
      2'b10:   res = a_mux ^ b_mux;
      default: res = sum_ext[WIDTH-1:0];
    endcase
`ifdef SEQ_ALU_SATURATE_EN
    if (op[1:0] == 2'b11 && add_ovf) begin
      res = a_mux[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op[4]) begin
            mcand_d = a;
            lo_d    = b;
            hi_d    = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_MUL;
          end else begin
            y_d         = res;
            prod_hi_d   = {WIDTH{1'b0}};
            cout_d      = (op[1:0] == 2'b11) && sum_ext[WIDTH];
            neg_d       = (op[1:0] == 2'b11) && !sum_ext[WIDTH] && op[2];
            zero_d      = (res == {WIDTH{1'b0}});
            ovf_d       = (op[1:0] == 2'b11) && add_ovf;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        hi_d  = hi_next;
        lo_d  = lo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = S_IDLE;
          y_d         = lo_next;
          prod_hi_d   = hi_next;
          cout_d      = 1'b0;
          neg_d       = 1'b0;
          zero_d      = (lo_next == {WIDTH{1'b0}});
          ovf_d       = (hi_next != {WIDTH{1'b0}});
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      y_q         <= {WIDTH{1'b0}};
      prod_hi_q   <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      y_q         <= y_d;
      prod_hi_q   <= prod_hi_d;
      cout_q      <= cout_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign prod_hi   = prod_hi_q;
  assign cout      = cout_q;
  assign neg       = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
//======================================================================
// Module   : tb_seq_alu
// Purpose  : Directed self-checking bench for seq_alu (WIDTH=8).
// Revision : 1.0 - initial release
//======================================================================
`default_nettype none

module tb_seq_alu;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] prod_hi;
  logic             cout;
  logic             neg;
  logic             zero;
  logic             overflow;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .prod_hi   (prod_hi),
    .cout      (cout),
    .neg       (neg),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operation and leave the bench 1ns after the accepting edge.
  task automatic issue(input logic [4:0] op_v, input logic [WIDTH-1:0] a_v,
                       input logic [WIDTH-1:0] b_v, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    op       = op_v;
    a        = a_v;
    b        = b_v;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags packed as {cout, neg, zero, overflow}
  function automatic logic [3:0] flags();
    return {cout, neg, zero, overflow};
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 5'd0;
    a         = '0;
    b         = '0;

    // 1. reset
    tick();
    tick();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.y",         32'(y),         32'h00);
    check("rst.prod_hi",   32'(prod_hi),   32'h00);
    check("rst.flags",     32'(flags()),   32'h0);
    check("rst.busy",      32'(busy),      32'd0);
    rst = 1'b0;
    tick();
    check("idle.in_ready", 32'(in_ready),  32'd1);

    // 2. add with signed overflow
    issue(5'b00011, 8'h7F, 8'h01, "add");
    check("add.out_valid", 32'(out_valid), 32'd1);
`ifdef SEQ_ALU_SATURATE_EN
    check("add.y",         32'(y),         32'h7F);
`else
    check("add.y",         32'(y),         32'h80);
`endif
    check("add.flags",     32'(flags()),   32'b0001);
    check("add.prod_hi",   32'(prod_hi),   32'h00);

    // 3. subtract
    issue(5'b00111, 8'h05, 8'h05, "sub0");
    check("sub0.y",        32'(y),         32'h00);
    check("sub0.flags",    32'(flags()),   32'b1010);
    issue(5'b00111, 8'h03, 8'h05, "subn");
    check("subn.y",        32'(y),         32'hFE);
    check("subn.flags",    32'(flags()),   32'b0100);

    // 4. multiply 0xFF*0xFF
    issue(5'b10000, 8'hFF, 8'hFF, "mulff");
    for (int i = 0; i < WIDTH; i++) begin
      check($sformatf("mulff.busy%0d", i),  32'(busy),     32'd1);
      check($sformatf("mulff.rdy%0d", i),   32'(in_ready), 32'd0);
      tick();
    end
    check("mulff.busy_end",  32'(busy),      32'd0);
    check("mulff.out_valid", 32'(out_valid), 32'd1);
    check("mulff.y",         32'(y),         32'h01);
    check("mulff.prod_hi",   32'(prod_hi),   32'hFE);
    check("mulff.flags",     32'(flags()),   32'b0001);

    // multiply 0x0C*0x0A
    issue(5'b10000, 8'h0C, 8'h0A, "mulc");
    for (int i = 0; i < WIDTH; i++) tick();
    check("mulc.out_valid",  32'(out_valid), 32'd1);
    check("mulc.y",          32'(y),         32'h78);
    check("mulc.prod_hi",    32'(prod_hi),   32'h00);
    check("mulc.flags",      32'(flags()),   32'b0000);

    // 5. backpressure with xor
    tick();
    out_ready = 1'b0;
    issue(5'b00010, 8'hF0, 8'hFF, "xor");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp.valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp.y%0d", i),     32'(y),         32'h0F);
      check($sformatf("bp.rdy%0d", i),   32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    issue(5'b00011, 8'h01, 8'h02, "b2b");
    check("b2b.out_valid",   32'(out_valid), 32'd1);
    check("b2b.y",           32'(y),         32'h03);
    check("b2b.flags",       32'(flags()),   32'b0000);
    tick();
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // 6. reset during multiply
    issue(5'b10000, 8'hFF, 8'hFF, "mulrst");
    tick();
    tick();
    tick();
    check("mulrst.busy_pre", 32'(busy),      32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mulrst.busy",     32'(busy),      32'd0);
    check("mulrst.out_valid",32'(out_valid), 32'd0);
    check("mulrst.in_ready", 32'(in_ready),  32'd1);
    issue(5'b00000, 8'hAA, 8'h0F, "and");
    check("and.out_valid",   32'(out_valid), 32'd1);
    check("and.y",           32'(y),         32'h0A);
    check("and.flags",       32'(flags()),   32'b0000);
    tick();
    check("and.busy_after",  32'(busy),      32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
